// File: rtl/rat_pkg.sv
// Shared definitions for the rational arithmetic blocks: state encoding,
// default operand width and the width of the common-power-of-two counter.
package rat_pkg;

    localparam int RAT_WIDTH = 32;

    typedef enum logic [2:0] {
        RAT_IDLE = 3'd0,
        RAT_TWOS = 3'd1,
        RAT_GCD  = 3'd2,
        RAT_DIV  = 3'd3,
        RAT_OUT  = 3'd4
    } rat_reduce_state_t;

    // k counts shared factors of two, which can reach WIDTH-1.
    function automatic int RAT_KW(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/rat_divu.sv
// Sequential restoring unsigned divider: one quotient bit per cycle,
// WIDTH iterations after start, then a single-cycle done pulse.
module rat_divu
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The quotient register doubles as the dividend shift register.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
            cnt_d  = CNT_INIT;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/rat_reduce.sv
// Reduces num/den to lowest terms: binary GCD over a/b with k shared twos,
// then divides both terms by g = a<<k. Valid/ready on both sides.
module rat_reduce
    import rat_pkg::*;
#(
    parameter int WIDTH = RAT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_err
);

    localparam int KW = RAT_KW(WIDTH);
    localparam logic [2:0] S_IDLE = RAT_IDLE;
    localparam logic [2:0] S_TWOS = RAT_TWOS;
    localparam logic [2:0] S_GCD  = RAT_GCD;
    localparam logic [2:0] S_DIV  = RAT_DIV;
    localparam logic [2:0] S_OUT  = RAT_OUT;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [KW-1:0]    K_ONE = KW'(1);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] n0_q, n0_d, d0_q, d0_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [KW-1:0]    k_q, k_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_num_q, out_num_d, out_den_q, out_den_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] g_sh;
    logic             div_start;
    logic [WIDTH-1:0] num_quo, num_rem, den_quo, den_rem;
    logic             num_done, den_done;

    assign g_sh = a_q << k_q;

    always_comb begin
        state_d     = state_q;
        n0_d        = n0_q;
        d0_d        = d0_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_num_d   = out_num_q;
        out_den_d   = out_den_q;
        out_err_d   = out_err_q;
        div_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    n0_d = in_num;
                    d0_d = in_den;
                    a_d  = in_num;
                    b_d  = in_den;
                    k_d  = '0;
                    if (in_den == '0) begin
                        out_num_d   = in_num;
                        out_den_d   = in_den;
                        out_err_d   = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else if (in_num == '0) begin
                        out_num_d   = '0;
                        out_den_d   = ONE;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        state_d = S_TWOS;
                    end
                end
            end
            S_TWOS: begin
                if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + K_ONE;
                end else begin
                    state_d = S_GCD;
                end
            end
            S_GCD: begin
                if (a_q == b_q) begin
                    // Already coprime: the original terms are the answer.
                    if (g_sh == ONE) begin
                        out_num_d   = n0_q;
                        out_den_d   = d0_q;
                        out_err_d   = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end else begin
                        div_start = 1'b1;
                        state_d   = S_DIV;
                    end
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            S_DIV: begin
                // Both dividers start together and finish on the same cycle.
                if (num_done && den_done) begin
                    out_num_d   = num_quo;
                    out_den_d   = den_quo;
                    out_err_d   = (num_rem != '0) || (den_rem != '0);
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n0_q        <= '0;
            d0_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_num_q   <= '0;
            out_den_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            n0_q        <= n0_d;
            d0_q        <= d0_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_num_q   <= out_num_d;
            out_den_q   <= out_den_d;
            out_err_q   <= out_err_d;
        end
    end

    rat_divu #(.WIDTH(WIDTH)) u_div_num (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (n0_q),
        .divisor   (g_sh),
        .quotient  (num_quo),
        .remainder (num_rem),
        .done      (num_done)
    );

    rat_divu #(.WIDTH(WIDTH)) u_div_den (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (d0_q),
        .divisor   (g_sh),
        .quotient  (den_quo),
        .remainder (den_rem),
        .done      (den_done)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_num   = out_num_q;
    assign out_den   = out_den_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_rat_reduce.sv
// Bench for rat_reduce: directed cases plus random pairs, scored against a
// Euclid-based reference that reduces each fraction with plain arithmetic.
module tb_rat_reduce;

    localparam int W  = 32;
    localparam int TO = 400;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_num;
    logic [W-1:0] in_den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_num;
    logic [W-1:0] out_den;
    logic         out_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    rat_reduce #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_den   (out_den),
        .out_err   (out_err)
    );

    task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A divide that leaves a remainder means g was not a common divisor.
    always @(negedge clk) begin
        if (!rst && dut.u_div_num.done) check("div_rem_num", {33'd0, dut.u_div_num.remainder}, '0);
        if (!rst && dut.u_div_den.done) check("div_rem_den", {33'd0, dut.u_div_den.remainder}, '0);
    end

    function automatic longint unsigned gcd(input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Packed as {err, num, den}.
    function automatic logic [2*W:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
        longint unsigned g;
        logic [W-1:0] rn, rd;
        if (d == 0) return {1'b1, n, d};
        if (n == 0) return {1'b0, 32'd0, 32'd1};
        g  = gcd(n, d);
        rn = W'(longint'(n) / g);
        rd = W'(longint'(d) / g);
        return {1'b0, rn, rd};
    endfunction

    function automatic logic [2*W:0] outs();
        return {out_err, out_num, out_den};
    endfunction

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_num   = n;
        in_den   = d;
        while (!in_ready && t < TO) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("accept_timeout", {64'd0, in_ready}, 65'd1);
        exp_q.push_back(model(n, d));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_num   = $urandom;
        in_den   = $urandom;
    endtask

    // lat = number of negedges after the accept edge until out_valid is seen.
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < TO);
        if (!out_valid) check("out_timeout", {64'd0, out_valid}, 65'd1);
    endtask

    task automatic recv(input int hold);
        logic [2*W:0] exp, snap;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 65'd0, 65'd1);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        snap = outs();
        check("result", snap, exp);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_data", outs(), snap);
            check("hold_valid", {64'd0, out_valid}, 65'd1);
            check("hold_in_ready", {64'd0, in_ready}, 65'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("valid_cleared", {64'd0, out_valid}, 65'd0);
        check("ready_back", {64'd0, in_ready}, 65'd1);
    endtask

    task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input int hold, output int lat);
        send(n, d);
        wait_out(lat);
        recv(hold);
    endtask

    initial begin
        int lat;
        logic [W-1:0] n, d, g;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_outs", outs(), '0);
        check("rst_valid", {64'd0, out_valid}, 65'd0);
        check("rst_in_ready", {64'd0, in_ready}, 65'd0);
        rst = 1'b0;
        #1 check("in_ready_before_edge", {64'd0, in_ready}, 65'd0);
        @(negedge clk);
        check("in_ready_after_edge", {64'd0, in_ready}, 65'd1);

        run_op(32'd6, 32'd8, 3, lat);
        check("div_path_6_8", {64'd0, lat > W}, 65'd1);

        run_op(32'd7, 32'd13, 0, lat);
        check("bypass_7_13", {64'd0, lat < W}, 65'd1);

        run_op(32'd0, 32'd5, 1, lat);
        check("lat_zero_num", 65'(lat), 65'd1);
        run_op(32'd5, 32'd0, 1, lat);
        check("lat_zero_den", 65'(lat), 65'd1);

        run_op(32'h8000_0000, 32'h4000_0000, 0, lat);
        check("lat_pow2", {64'd0, lat <= 4 * W + W + 3}, 65'd1);

        // Backpressure with a competing pair waiting on the input.
        send(32'd12, 32'd18);
        wait_out(lat);
        in_valid = 1'b1;
        in_num   = 32'd100;
        in_den   = 32'd75;
        recv(20);
        exp_q.push_back(model(32'd100, 32'd75));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_num   = $urandom;
        in_den   = $urandom;
        wait_out(lat);
        recv(0);

        // Abort a division in progress.
        send(32'd48, 32'd36);
        repeat (15) @(negedge clk);
        check("abort_not_done", {64'd0, out_valid}, 65'd0);
        #2 rst = 1'b1;
        #1;
        check("abort_outs", outs(), '0);
        check("abort_valid", {64'd0, out_valid}, 65'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        run_op(32'd9, 32'd27, 0, lat);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: begin n = $urandom; d = '0; end
                1: begin n = '0; d = $urandom_range(1, 1000); end
                2, 3: begin n = $urandom; d = $urandom; end
                default: begin
                    g = $urandom_range(1, 300) << $urandom_range(0, 6);
                    n = g * $urandom_range(1, 5000);
                    d = g * $urandom_range(1, 5000);
                end
            endcase
            run_op(n, d, $urandom_range(0, 3), lat);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
